forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit.sv | 88 ++++++++
 tb/tb_forward_hazard_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// Operand-forwarding and load-use hazard detection for a five-stage pipeline.
// Tracks the EX, MEM and WB instructions and selects bypass paths for EX operands.
module forward_hazard_unit #(
  parameter int N  = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [N-1:0]  Rs1Add,
  input  logic [N-1:0]  Rs2Add,
  input  logic [N-1:0]  RdAdd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwdA,
  output logic [1:0]    fwdB,
  output logic [CW-1:0] stall_cnt
);

  logic         ex_vld_p0, ex_rw_p0, ex_mr_p0;
  logic [N-1:0] ex_rd_p0, ex_rs1_p0, ex_rs2_p0;
  logic         mem_vld_p1, mem_rw_p1, mem_mr_p1;
  logic [N-1:0] mem_rd_p1;
  logic         wb_vld_p2, wb_rw_p2, wb_mr_p2;
  logic [N-1:0] wb_rd_p2;
  logic         unused_mr;

  // x0 is hardwired, so a slot targeting it never produces a usable result
  function automatic logic writes(input logic vld, input logic rw,
                                  input logic [N-1:0] rd, input logic [N-1:0] r);
    return vld & rw & (rd == r) & (r != '0);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Load-use hazard: the loaded value is not available until the load leaves MEM
  assign stall = id_valid & ~flush & ex_mr_p0 &
                 (writes(ex_vld_p0, ex_rw_p0, ex_rd_p0, Rs1Add) |
                  writes(ex_vld_p0, ex_rw_p0, ex_rd_p0, Rs2Add));

  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (ex_vld_p0) begin
      if (writes(mem_vld_p1, mem_rw_p1, mem_rd_p1, ex_rs1_p0))     fwdA = 2'b01;
      else if (writes(wb_vld_p2, wb_rw_p2, wb_rd_p2, ex_rs1_p0))   fwdA = 2'b10;
      if (writes(mem_vld_p1, mem_rw_p1, mem_rd_p1, ex_rs2_p0))     fwdB = 2'b01;
      else if (writes(wb_vld_p2, wb_rw_p2, wb_rd_p2, ex_rs2_p0))   fwdB = 2'b10;
    end
  end

  // Stage boundary ID->EX->MEM->WB: control (valid bits, counter)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_vld_p0  <= 1'b0;
      mem_vld_p1 <= 1'b0;
      wb_vld_p2  <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      ex_vld_p0  <= id_valid & ~stall & ~flush;
      mem_vld_p1 <= ex_vld_p0;
      wb_vld_p2  <= mem_vld_p1;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Stage boundary ID->EX->MEM->WB: data fields, qualified by the valid bits
  always_ff @(posedge clk) begin
    ex_rd_p0  <= RdAdd;
    ex_rs1_p0 <= Rs1Add;
    ex_rs2_p0 <= Rs2Add;
    ex_rw_p0  <= id_regwrite;
    ex_mr_p0  <= id_memread;
    mem_rd_p1 <= ex_rd_p0;
    mem_rw_p1 <= ex_rw_p0;
    mem_mr_p1 <= ex_mr_p0;
    wb_rd_p2  <= mem_rd_p1;
    wb_rw_p2  <= mem_rw_p1;
    wb_mr_p2  <= mem_mr_p1;
  end

  assign unused_mr = mem_mr_p1 ^ wb_mr_p2;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit (CW=2 so counter saturation is reachable).
// Expected outputs are queued as each step is driven and compared before the next edge.
module tb_forward_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_regwrite, id_memread, flush;
  logic [4:0] Rs1Add, Rs2Add, RdAdd;
  logic       stall;
  logic [1:0] fwdA, fwdB;
  logic [1:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      tag;
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] cnt;
  } exp_t;

  exp_t q[$];

  forward_hazard_unit #(.N(5), .CW(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .Rs1Add(Rs1Add), .Rs2Add(Rs2Add),
    .RdAdd(RdAdd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall), .fwdA(fwdA), .fwdB(fwdB), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic push(input string tag, input logic s, input logic [1:0] a,
                      input logic [1:0] b, input logic [1:0] c);
    exp_t e;
    e.tag = tag; e.stall = s; e.fa = a; e.fb = b; e.cnt = c;
    q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".stall"}, {7'b0, stall}, {7'b0, e.stall});
      chk({e.tag, ".fwdA"},  {6'b0, fwdA},  {6'b0, e.fa});
      chk({e.tag, ".fwdB"},  {6'b0, fwdB},  {6'b0, e.fb});
      chk({e.tag, ".cnt"},   {6'b0, stall_cnt}, {6'b0, e.cnt});
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    id_valid = v; Rs1Add = r1; Rs2Add = r2; RdAdd = rd;
    id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  // One cycle: drive decode inputs, queue expected outputs, compare, advance past the edge
  task automatic cyc(input string tag, input logic v, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd, input logic rw,
                     input logic mr, input logic fl, input logic es,
                     input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] ec);
    drive(v, r1, r2, rd, rw, mr, fl);
    push(tag, es, ea, eb, ec);
    #2;
    check_all();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] c;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    push("reset", 0, 2'b00, 2'b00, 2'd0);
    check_all();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back ALU pair
    cyc("alu_w",  1, 1, 2, 5, 1, 0, 0,  0, 2'b00, 2'b00, 2'd0);
    cyc("alu_r",  1, 5, 6, 8, 1, 0, 0,  0, 2'b00, 2'b00, 2'd0);
    cyc("alu_f",  0, 0, 0, 0, 0, 0, 0,  0, 2'b01, 2'b00, 2'd0);

    // Distance-two dependency through WB
    cyc("d2_w",   1, 0, 0, 7, 1, 0, 0,  0, 2'b00, 2'b00, 2'd0);
    cyc("d2_u",   1, 1, 2, 9, 1, 0, 0,  0, 2'b00, 2'b00, 2'd0);
    cyc("d2_r",   1, 1, 7, 10, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0);
    cyc("d2_f",   0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b10, 2'd0);

    // Writers to x7 in both MEM and WB: MEM wins
    cyc("pr_w1",  1, 0, 0, 7, 1, 0, 0,  0, 2'b00, 2'b00, 2'd0);
    cyc("pr_w2",  1, 0, 0, 7, 1, 0, 0,  0, 2'b00, 2'b00, 2'd0);
    cyc("pr_r",   1, 7, 7, 11, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0);
    cyc("pr_f",   0, 0, 0, 0, 0, 0, 0,  0, 2'b01, 2'b01, 2'd0);
    cyc("bubble", 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'd0);

    // Load-use: one stall; the load has reached WB when the reader enters EX
    cyc("lu_ld",  1, 1, 0, 3, 1, 1, 0,  0, 2'b00, 2'b00, 2'd0);
    cyc("lu_st",  1, 3, 2, 12, 1, 0, 0, 1, 2'b00, 2'b00, 2'd0);
    cyc("lu_hold",1, 3, 2, 12, 1, 0, 0, 0, 2'b00, 2'b00, 2'd1);
    cyc("lu_fwd", 0, 0, 0, 0, 0, 0, 0,  0, 2'b10, 2'b00, 2'd1);

    // x0 guard for forwarding and for load-use
    cyc("x0_w",   1, 1, 2, 0, 1, 0, 0,  0, 2'b00, 2'b00, 2'd1);
    cyc("x0_r",   1, 0, 0, 13, 1, 0, 0, 0, 2'b00, 2'b00, 2'd1);
    cyc("x0_ld",  1, 0, 0, 0, 1, 1, 0,  0, 2'b00, 2'b00, 2'd1);
    cyc("x0_lr",  1, 0, 0, 13, 1, 0, 0, 0, 2'b00, 2'b00, 2'd1);
    cyc("x0_f",   0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'd1);

    // Flush overrides a load-use hazard and bubbles EX
    cyc("fl_ld",  1, 1, 2, 4, 1, 1, 0,  0, 2'b00, 2'b00, 2'd1);
    cyc("fl_r",   1, 4, 0, 14, 1, 0, 1, 0, 2'b00, 2'b00, 2'd1);
    cyc("fl_chk", 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 2'd1);

    // Repeated load-use stalls on rs2 until the counter saturates
    c = 2'd1;
    for (int i = 0; i < 5; i++) begin
      cyc("sat_ld", 1, 0, 0, 6, 1, 1, 0,  0, 2'b00, 2'b00, c);
      cyc("sat_st", 1, 1, 6, 15, 1, 0, 0, 1, 2'b00, 2'b00, c);
      c = (c == 2'd3) ? 2'd3 : c + 2'd1;
      cyc("sat_hd", 1, 1, 6, 15, 1, 0, 0, 0, 2'b00, 2'b00, c);
      cyc("sat_fw", 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b10, c);
    end

    // Asynchronous reset in the middle of a stall
    cyc("rs_ld",  1, 0, 0, 6, 1, 1, 0,  0, 2'b00, 2'b00, 2'd3);
    drive(1, 6, 0, 15, 1, 0, 0);
    push("rs_stall", 1, 2'b00, 2'b00, 2'd3);
    #2;
    check_all();
    rst = 1'b1;
    push("rs_async", 0, 2'b00, 2'b00, 2'd0);
    #1;
    check_all();
    @(posedge clk);
    #1;
    push("rs_held", 0, 2'b00, 2'b00, 2'd0);
    check_all();
    rst = 1'b0;

    // First instruction after reset enters EX on the first edge
    cyc("post_w", 1, 1, 2, 5, 1, 0, 0,  0, 2'b00, 2'b00, 2'd0);
    cyc("post_r", 1, 5, 0, 8, 1, 0, 0,  0, 2'b00, 2'b00, 2'd0);
    cyc("post_f", 0, 0, 0, 0, 0, 0, 0,  0, 2'b01, 2'b00, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
